// File: rtl/irq_pkg.sv
// Shared constants and FSM encoding for the interrupt arbiter.
package irq_pkg;

    localparam int unsigned NSRC = 8;

    localparam logic [1:0] OFF_MASK = 2'd0;
    localparam logic [1:0] OFF_PEND = 2'd1;
    localparam logic [1:0] OFF_OVF  = 2'd2;
    localparam logic [1:0] OFF_CUR  = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitAck = 2'd1,
        StGap     = 2'd2
    } irq_state_e;

endpackage

// File: rtl/prio_enc8.sv
// Lowest-set-bit encoder: bit 0 has the highest priority.
module prio_enc8 (
    input  logic [7:0] req,
    output logic       valid,
    output logic [2:0] idx
);

    always_comb begin
        valid = |req;
        idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Memory-mapped interrupt controller: latches request pulses, masks them and
// dispatches the highest-priority one to the core with a toggle-style intr.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter logic [15:0] BASE = 16'h0024
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [NSRC-1:0] irq,
    input  logic [15:0]     address,
    input  logic [7:0]      wdata,
    input  logic            we,
    input  logic            read,
    output logic [7:0]      rdata,
    output logic            hit,
    output logic            intr,
    output logic [2:0]      vect,
    input  logic            ack
);

    irq_state_e      state;
    logic [NSRC-1:0] mask, pend, ovf;
    logic [NSRC-1:0] pend_next, ovf_next, pend_clr, ovf_clr;
    logic [15:0]     offset;
    logic [1:0]      off;
    logic            mask_we, pend_we, ovf_we, ack_accept;
    logic            sel_valid;
    logic [2:0]      sel_idx;
    logic            unused_read;

    // read strobe has no side effects on any register
    assign unused_read = read;

    // Full 16-bit window compare; wrap-around of the subtraction lands outside.
    assign offset = address - BASE;
    assign hit    = (offset < 16'd4);
    assign off    = offset[1:0];

    assign mask_we    = we && hit && (off == OFF_MASK);
    assign pend_we    = we && hit && (off == OFF_PEND);
    assign ovf_we     = we && hit && (off == OFF_OVF);
    assign ack_accept = (state == StWaitAck) && ack;

    always_comb begin
        pend_clr  = (pend_we ? wdata : '0) | (ack_accept ? (NSRC'(1) << vect) : '0);
        ovf_clr   = ovf_we ? wdata : '0;
        // new requests override any clear arriving in the same cycle
        pend_next = (pend & ~pend_clr) | irq;
        ovf_next  = (ovf & ~ovf_clr) | (irq & pend);
    end

    always_comb begin
        rdata = 8'h00;
        if (hit) begin
            unique case (off)
                OFF_MASK: rdata = mask;
                OFF_PEND: rdata = pend;
                OFF_OVF:  rdata = ovf;
                OFF_CUR:  rdata = {4'b0000, state == StWaitAck, vect};
                default:  rdata = 8'h00;
            endcase
        end
    end

    prio_enc8 u_prio_enc8 (
        .req   (pend & mask),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= StIdle;
            mask  <= '0;
            pend  <= '0;
            ovf   <= '0;
            intr  <= 1'b0;
            vect  <= 3'd0;
        end else begin
            pend <= pend_next;
            ovf  <= ovf_next;
            if (mask_we) begin
                mask <= wdata;
            end
            case (state)
                StIdle: begin
                    if (sel_valid) begin
                        vect  <= sel_idx;
                        intr  <= ~intr;
                        state <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (ack) begin
                        state <= StGap;
                    end
                end
                StGap:   state <= StIdle;
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/irq_arbiter.md
Name: irq_arbiter

Overview:
Memory-mapped interrupt controller between the SoC's event sources (keyboard done, timers, future UART/SD) and the AVR core's single interrupt input (intr/vect/ack).
- Latches up to 8 single-cycle request pulses as pending bits.
- Applies a software mask and picks the highest-priority unmasked request.
- Signals the core with the toggle-style intr, holds vect stable until ack.
- Registers sit in low data space beside the other I/O ports; the top-level router muxes rdata when hit=1.

Parameters:
BASE, 16'h0024, address of the MASK register; PEND = BASE+1, OVF = BASE+2, CUR = BASE+3.
NSRC, 8, number of sources. Fixed at 8; vect is 3 bits.

Ports:
clock  in  1  system clock (clock_25 domain)
reset_n  in  1  asynchronous, active-low reset
irq  in  8  request pulses, one cycle each, already synchronous to clock; bit i = vector i
address  in  16  CPU data address
wdata  in  8  CPU write data
we  in  1  CPU write strobe
read  in  1  CPU read strobe (clears nothing; informational only)
rdata  out  8  register read data, combinational from address
hit  out  1  1 when address is in BASE..BASE+3
intr  out  1  toggles once per dispatched interrupt
vect  out  3  vector of the current dispatch, stable from toggle until ack
ack  in  1  one-cycle pulse from the core when it enters the handler

Behaviour:
- Reset (async, reset_n=0): mask=8'h00, pend=8'h00, ovf=8'h00, cur=8'h00, intr=0, vect=3'd0, state=IDLE. Reset asserted mid-dispatch abandons it; no ack is expected afterwards.
- Pending latch (every cycle):
  - pend_next = (pend & ~clr) | irq.
  - clr = (we && address==PEND ? wdata : 0) | (ack-accept in WAIT_ACK ? onehot(vect) : 0).
  - Set wins over any clear in the same cycle.
- Overflow: irq[i]=1 while pend[i] already 1 (before this cycle's clear) sets ovf[i]. Sticky; write-1-to-clear at OVF; set wins.
- MASK: read/write. Bit=1 enables the source. Masking does not clear pend.
- CUR: read-only. {4'b0, busy, vect}; busy=1 in WAIT_ACK.
- Writes to CUR are ignored. Addresses outside the window give hit=0, rdata=8'h00.
- Priority: lowest index wins; vector 0 (keyboard) is highest.
- FSM states: IDLE, WAIT_ACK, GAP.
  - IDLE: if (pend & mask) != 0, then vect <= index of lowest set bit, intr <= ~intr, go WAIT_ACK. Otherwise stay.
  - WAIT_ACK: vect frozen. On ack: clear pend[vect], go GAP. Mask/PEND writes here do not cancel the dispatch. ack still completes normally even if software already cleared pend[vect]. No timeout.
  - GAP: one cycle, no dispatch, then IDLE. Guarantees at least 2 cycles between intr toggles.
- ack outside WAIT_ACK: ignored.
- Latency: irq pulse at edge N → pend bit visible after N → intr toggles at edge N+1 if IDLE and unmasked. That is 2 edges from the pulse cycle to the toggle.
- Back-to-back: ack at edge A → GAP → next toggle at edge A+2 at the earliest.
- Width rules: all registers 8-bit; the address compare is a full 16-bit compare.

Decomposition:
- Shared package (irq_pkg): register offsets OFF_MASK=0, OFF_PEND=1, OFF_OVF=2, OFF_CUR=3; FSM state encoding (IDLE=2'd0, WAIT_ACK=2'd1, GAP=2'd2); NSRC.
- One sub-module, prio_enc8: combinational lowest-set-bit encoder, 8-bit in → {valid, idx[2:0]}.
- Everything else stays in irq_arbiter.

Test Plan:
- Reset: hold reset_n=0 with irq=8'hFF → after release, rdata at MASK/PEND/OVF/CUR all 8'h00, intr=0. Then pulse irq[3] with mask=0 → PEND reads 8'h08, intr unchanged.
- Single dispatch: write MASK=8'h01, pulse irq[0] at edge N → intr toggles at edge N+1, vect=0, CUR=8'h08. Ack → PEND=8'h00, CUR=8'h00.
- Priority: MASK=8'hFF, pulse irq[5] and irq[2] in the same cycle → vect=2 first. Ack → vect=5 dispatched exactly 2 edges after the ack edge.
- Overflow and set-wins:
  - Two irq[4] pulses before ack → OVF=8'h10. Write OVF=8'h10 → reads 8'h00.
  - Write PEND=8'h10 in the same cycle as an irq[4] pulse → PEND bit 4 still 1.
- Mid-dispatch change: in WAIT_ACK with vect=1, write MASK=8'h00 → vect stays 1, dispatch completes on ack. No further toggle until MASK re-enabled.
- Reset mid-dispatch: pulse reset_n low during WAIT_ACK → state IDLE, intr=0, PEND=8'h00. A stray ack afterwards has no effect.
